// File: rtl/decode_stage_pkg.sv
// Shared decode types: opcodes, ID/EX bundle, decode controls.
// Opcode-to-control table lives here so every stage agrees on it.
package decode_stage_pkg;

    localparam int D_SIZE_DEF = 32;

    typedef enum logic [5:0] {
        OP_ADD  = 6'h00,
        OP_ADDI = 6'h01,
        OP_SUB  = 6'h02,
        OP_SUBI = 6'h03,
        OP_MUL  = 6'h04,
        OP_MULI = 6'h05,
        OP_OR   = 6'h06,
        OP_ORI  = 6'h07,
        OP_AND  = 6'h08,
        OP_ANDI = 6'h09,
        OP_XOR  = 6'h0A,
        OP_XORI = 6'h0B,
        OP_LDW  = 6'h0C,
        OP_STW  = 6'h0D,
        OP_BZ   = 6'h0E,
        OP_BEQ  = 6'h0F,
        OP_JR   = 6'h10,
        OP_HALT = 6'h11
    } opcode_e;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic use_rs;
        logic use_rt;
        logic rd_is_rd;
        logic rd_is_rt;
        logic imm_en;
    } dec_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic        branch;
        logic        mem_read;
        logic        mem_to_reg;
        logic        mem_write;
        logic [31:0] pc4;
    } id_ex_t;

    // halt and undefined opcodes fall through to all-zero controls
    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        d = '0;
        unique case (1'b1)
            (op < 6'h0C) && !op[0]: begin
                d.use_rs     = 1'b1;
                d.use_rt     = 1'b1;
                d.rd_is_rd   = 1'b1;
                d.mem_to_reg = 1'b1;
            end
            (op < 6'h0C) && op[0]: begin
                d.use_rs     = 1'b1;
                d.rd_is_rt   = 1'b1;
                d.imm_en     = 1'b1;
                d.mem_to_reg = 1'b1;
            end
            (op == OP_LDW): begin
                d.use_rs     = 1'b1;
                d.rd_is_rt   = 1'b1;
                d.imm_en     = 1'b1;
                d.mem_read   = 1'b1;
                d.mem_to_reg = 1'b1;
            end
            (op == OP_STW): begin
                d.use_rs    = 1'b1;
                d.use_rt    = 1'b1;
                d.imm_en    = 1'b1;
                d.mem_write = 1'b1;
            end
            (op == OP_BZ) || (op == OP_JR): begin
                d.use_rs = 1'b1;
                d.imm_en = 1'b1;
                d.branch = 1'b1;
            end
            (op == OP_BEQ): begin
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
                d.imm_en = 1'b1;
                d.branch = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Register file: 2 async read ports, 1 write port, write-through.
// R[0] is hardwired to zero and drops writes.
module regfile
    import decode_stage_pkg::*;
#(
    parameter int D_SIZE = D_SIZE_DEF,
    parameter int NREG   = 32,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     i_ra0,
    input  logic [AW-1:0]     i_ra1,
    output logic [D_SIZE-1:0] o_rd0,
    output logic [D_SIZE-1:0] o_rd1,
    input  logic              i_we,
    input  logic [AW-1:0]     i_wa,
    input  logic [D_SIZE-1:0] i_wd
);

    logic [D_SIZE-1:0] r_mem [NREG];
    logic              w_hit0;
    logic              w_hit1;

    assign w_hit0 = i_we && (i_wa == i_ra0);
    assign w_hit1 = i_we && (i_wa == i_ra1);

    // reads see a same-cycle write so WB->ID needs no extra cycle
    always_comb begin
        o_rd0 = r_mem[i_ra0];
        o_rd1 = r_mem[i_ra1];
        if (w_hit0) o_rd0 = i_wd;
        if (w_hit1) o_rd1 = i_wd;
        if (i_ra0 == '0) o_rd0 = '0;
        if (i_ra1 == '0) o_rd1 = '0;
    end

    // write port; whole array clears on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else if (i_we && (i_wa != '0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: regfile read, load-use stall,
// flush/halt handling and the registered ID/EX bundle.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int D_SIZE = D_SIZE_DEF,
    parameter int NREG   = 32,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [31:0]       inst,
    input  logic [31:0]       pc4_in,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_addr,
    input  logic [D_SIZE-1:0] wb_data,
    input  logic              flush,
    output logic              stall_if,
    output logic              halted,
    output logic              ex_valid,
    output logic [5:0]        ex_opcode,
    output logic [D_SIZE-1:0] ex_rs_val,
    output logic [D_SIZE-1:0] ex_rt_val,
    output logic [AW-1:0]     ex_rd,
    output logic [D_SIZE-1:0] ex_imm,
    output logic [31:0]       ex_pc4,
    output logic              ex_branch,
    output logic              ex_mem_read,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_write
);

    id_ex_t            r_ex;
    logic [D_SIZE-1:0] r_rs_val;
    logic [D_SIZE-1:0] r_rt_val;
    logic [AW-1:0]     r_rd;
    logic [D_SIZE-1:0] r_imm;
    logic              r_halted;

    id_ex_t            w_ex;
    logic [D_SIZE-1:0] w_rs_val;
    logic [D_SIZE-1:0] w_rt_val;
    logic [AW-1:0]     w_rd;
    logic [D_SIZE-1:0] w_imm;

    logic [5:0]        w_op;
    logic [AW-1:0]     w_rs;
    logic [AW-1:0]     w_rt;
    logic [AW-1:0]     w_rdf;
    logic [D_SIZE-1:0] w_sext;
    logic [D_SIZE-1:0] w_rd0;
    logic [D_SIZE-1:0] w_rd1;
    dec_t              w_dec;
    logic              w_hazard;
    logic              w_issue;

    assign w_op   = inst[31:26];
    assign w_rs   = AW'(inst[25:21]);
    assign w_rt   = AW'(inst[20:16]);
    assign w_rdf  = AW'(inst[15:11]);
    assign w_sext = {{(D_SIZE-16){inst[15]}}, inst[15:0]};
    assign w_dec  = decode(w_op);

    regfile #(
        .D_SIZE (D_SIZE),
        .NREG   (NREG)
    ) u_rf (
        .clk   (clk),
        .reset (reset),
        .i_ra0 (w_rs),
        .i_ra1 (w_rt),
        .o_rd0 (w_rd0),
        .o_rd1 (w_rd1),
        .i_we  (wb_we),
        .i_wa  (wb_addr),
        .i_wd  (wb_data)
    );

    // load in EX feeding a source actually read here
    assign w_hazard = if_valid && !r_halted
                   && r_ex.valid && r_ex.mem_read
                   && (r_rd != '0)
                   && ((w_dec.use_rs && (w_rs == r_rd))
                    || (w_dec.use_rt && (w_rt == r_rd)));

    assign w_issue  = if_valid && !r_halted && !flush && !w_hazard;
    assign stall_if = r_halted || (w_hazard && !flush);

    // next ID/EX content: decoded instruction or an all-zero bubble
    always_comb begin
        w_ex     = '0;
        w_rs_val = '0;
        w_rt_val = '0;
        w_rd     = '0;
        w_imm    = '0;
        if (w_issue) begin
            w_ex.valid      = 1'b1;
            w_ex.opcode     = w_op;
            w_ex.branch     = w_dec.branch;
            w_ex.mem_read   = w_dec.mem_read;
            w_ex.mem_to_reg = w_dec.mem_to_reg;
            w_ex.mem_write  = w_dec.mem_write;
            w_ex.pc4        = pc4_in;
            if (w_dec.use_rs)   w_rs_val = w_rd0;
            if (w_dec.use_rt)   w_rt_val = w_rd1;
            if (w_dec.rd_is_rd) w_rd     = w_rdf;
            if (w_dec.rd_is_rt) w_rd     = w_rt;
            if (w_dec.imm_en)   w_imm    = w_sext;
        end
    end

    // ID/EX pipeline register and sticky halt flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex     <= '0;
            r_rs_val <= '0;
            r_rt_val <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_halted <= 1'b0;
        end else begin
            r_ex     <= w_ex;
            r_rs_val <= w_rs_val;
            r_rt_val <= w_rt_val;
            r_rd     <= w_rd;
            r_imm    <= w_imm;
            r_halted <= r_halted || (w_issue && (w_op == OP_HALT));
        end
    end

    assign halted        = r_halted;
    assign ex_valid      = r_ex.valid;
    assign ex_opcode     = r_ex.opcode;
    assign ex_rs_val     = r_rs_val;
    assign ex_rt_val     = r_rt_val;
    assign ex_rd         = r_rd;
    assign ex_imm        = r_imm;
    assign ex_pc4        = r_ex.pc4;
    assign ex_branch     = r_ex.branch;
    assign ex_mem_read   = r_ex.mem_read;
    assign ex_mem_to_reg = r_ex.mem_to_reg;
    assign ex_mem_write  = r_ex.mem_write;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage at D_SIZE=64.
// Expected ID/EX content is pushed at drive time, popped after the edge.
module tb_decode_stage;

    localparam int DS = 64;
    localparam int NR = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_valid = 1'b0;
    logic [31:0]   inst = '0;
    logic [31:0]   pc4_in = '0;
    logic          wb_we = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DS-1:0] wb_data = '0;
    logic          flush = 1'b0;
    logic          stall_if, halted, ex_valid;
    logic [5:0]    ex_opcode;
    logic [DS-1:0] ex_rs_val, ex_rt_val, ex_imm;
    logic [AW-1:0] ex_rd;
    logic [31:0]   ex_pc4;
    logic          ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write;

    always #5 clk = ~clk;

    decode_stage #(.D_SIZE(DS), .NREG(NR)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .inst(inst),
        .pc4_in(pc4_in), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .stall_if(stall_if),
        .halted(halted), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_rd(ex_rd),
        .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write)
    );

    typedef struct packed {
        logic          v;
        logic [5:0]    op;
        logic [DS-1:0] rsv;
        logic [DS-1:0] rtv;
        logic [4:0]    rd;
        logic [DS-1:0] imm;
        logic [31:0]   pc4;
        logic          br, mr, m2r, mw;
    } out_t;

    typedef struct packed {
        out_t v;
        out_t m;
    } sb_t;

    sb_t           sb[$];
    logic [DS-1:0] sh [NR];
    int            n_vec = 0;
    int            n_miss = 0;
    sb_t           x;
    out_t          a;

    function automatic out_t dut_out();
        return out_t'({ex_valid, ex_opcode, ex_rs_val, ex_rt_val,
                       ex_rd, ex_imm, ex_pc4, ex_branch, ex_mem_read,
                       ex_mem_to_reg, ex_mem_write});
    endfunction

    function automatic logic [31:0] mk_r(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'h0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic sb_t model(input logic [31:0] in,
                                  input logic [31:0] pc);
        sb_t s;
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic [DS-1:0] sx;
        op = in[31:26];
        rs = in[25:21];
        rt = in[20:16];
        sx = {{(DS-16){in[15]}}, in[15:0]};
        s = '0;
        s.m = '1;
        s.v.v = 1'b1;
        s.v.op = op;
        s.v.pc4 = pc;
        if (op < 6'h0C && !op[0]) begin
            s.v.rsv = sh[rs]; s.v.rtv = sh[rt];
            s.v.rd = in[15:11]; s.v.m2r = 1'b1;
        end else if (op < 6'h0C) begin
            s.v.rsv = sh[rs]; s.v.rd = rt;
            s.v.imm = sx; s.v.m2r = 1'b1;
        end else if (op == 6'h0C) begin
            s.v.rsv = sh[rs]; s.v.rd = rt; s.v.imm = sx;
            s.v.mr = 1'b1; s.v.m2r = 1'b1;
        end else if (op == 6'h0D) begin
            s.v.rsv = sh[rs]; s.v.rtv = sh[rt];
            s.v.mw = 1'b1; s.m.imm = '0;
        end else if (op == 6'h0E || op == 6'h10) begin
            s.v.rsv = sh[rs]; s.v.imm = sx; s.v.br = 1'b1;
        end else if (op == 6'h0F) begin
            s.v.rsv = sh[rs]; s.v.rtv = sh[rt];
            s.v.imm = sx; s.v.br = 1'b1;
        end
        return s;
    endfunction

    function automatic sb_t bubble();
        sb_t s;
        s = '0;
        s.m.v = 1'b1; s.m.br = 1'b1; s.m.mr = 1'b1;
        s.m.m2r = 1'b1; s.m.mw = 1'b1;
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i,
                         input logic [31:0] p, input logic f);
        if_valid = v; inst = i; pc4_in = p; flush = f;
    endtask

    task automatic wb(input logic [4:0] ad, input logic [DS-1:0] d);
        drive(1'b0, '0, '0, 1'b0);
        wb_we = 1'b1; wb_addr = ad; wb_data = d;
        if (ad != 0) sh[ad] = d;
        step();
        wb_we = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NR; i++) sh[i] = '0;
        reset = 1'b0;
        drive(1'b1, mk_r(6'h00, 5'd1, 5'd2, 5'd3), 32'h4, 1'b0);
        #12;
        n_vec++;
        if (dut_out() !== '0 || halted !== 1'b0 || stall_if !== 1'b0) begin
            n_miss++;
            $display("FAIL reset: got %h h=%b s=%b want 0", dut_out(),
                     halted, stall_if);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        step();
    endtask

    task automatic test_bypass();
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 64'h1234; sh[5] = 64'h1234;
        drive(1'b1, mk_r(6'h00, 5'd5, 5'd0, 5'd6), 32'h10, 1'b0);
        sb.push_back(model(inst, pc4_in));
        step();
        wb_we = 1'b0;
        x = sb.pop_front(); a = dut_out(); n_vec++;
        if ((a & x.m) !== (x.v & x.m) || ex_rs_val !== 64'h1234) begin
            n_miss++;
            $display("FAIL bypass: got %h want %h", a & x.m, x.v & x.m);
        end
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 64'hFF;
        drive(1'b1, mk_r(6'h02, 5'd0, 5'd0, 5'd7), 32'h14, 1'b0);
        sb.push_back(model(inst, pc4_in));
        step();
        wb_we = 1'b0;
        x = sb.pop_front(); a = dut_out(); n_vec++;
        if ((a & x.m) !== (x.v & x.m)) begin
            n_miss++;
            $display("FAIL r0: got %h want %h", a & x.m, x.v & x.m);
        end
        drive(1'b0, '0, '0, 1'b0);
        step();
    endtask

    task automatic test_load_use();
        wb(5'd3, 64'hAAAA); wb(5'd2, 64'h5); wb(5'd1, 64'h100);
        drive(1'b1, mk_i(6'h0C, 5'd1, 5'd3, 16'h4), 32'h104, 1'b0);
        sb.push_back(model(inst, pc4_in));
        step();
        x = sb.pop_front(); a = dut_out(); n_vec++;
        if ((a & x.m) !== (x.v & x.m)) begin
            n_miss++;
            $display("FAIL ldw: got %h want %h", a & x.m, x.v & x.m);
        end
        drive(1'b1, mk_r(6'h00, 5'd3, 5'd2, 5'd4), 32'h108, 1'b0);
        #1; n_vec++;
        if (stall_if !== 1'b1) begin
            n_miss++;
            $display("FAIL lu_stall: got %b want 1", stall_if);
        end
        sb.push_back(bubble());
        step();
        x = sb.pop_front(); a = dut_out(); n_vec++;
        if ((a & x.m) !== (x.v & x.m)) begin
            n_miss++;
            $display("FAIL lu_bubble: got %h want %h", a & x.m, x.v & x.m);
        end
        n_vec++;
        if (stall_if !== 1'b0) begin
            n_miss++;
            $display("FAIL lu_release: got %b want 0", stall_if);
        end
        sb.push_back(model(inst, pc4_in));
        step();
        x = sb.pop_front(); a = dut_out(); n_vec++;
        if ((a & x.m) !== (x.v & x.m)) begin
            n_miss++;
            $display("FAIL lu_issue: got %h want %h", a & x.m, x.v & x.m);
        end
        drive(1'b0, '0, '0, 1'b0);
        step();
    endtask

    task automatic test_no_stall_dest();
        drive(1'b1, mk_i(6'h0C, 5'd1, 5'd3, 16'h8), 32'h200, 1'b0);
        step();
        drive(1'b1, mk_i(6'h01, 5'd1, 5'd3, 16'h7), 32'h204, 1'b0);
        #1; n_vec++;
        if (stall_if !== 1'b0) begin
            n_miss++;
            $display("FAIL dest_stall: got %b want 0", stall_if);
        end
        sb.push_back(model(inst, pc4_in));
        step();
        x = sb.pop_front(); a = dut_out(); n_vec++;
        if ((a & x.m) !== (x.v & x.m)) begin
            n_miss++;
            $display("FAIL dest_issue: got %h want %h", a & x.m, x.v & x.m);
        end
        drive(1'b0, '0, '0, 1'b0);
        step();
    endtask

    task automatic test_flush_hazard();
        drive(1'b1, mk_i(6'h0C, 5'd1, 5'd3, 16'h0), 32'h300, 1'b0);
        step();
        drive(1'b1, mk_r(6'h00, 5'd3, 5'd2, 5'd4), 32'h304, 1'b1);
        #1; n_vec++;
        if (stall_if !== 1'b0) begin
            n_miss++;
            $display("FAIL flush_stall: got %b want 0", stall_if);
        end
        sb.push_back(bubble());
        step();
        x = sb.pop_front(); a = dut_out(); n_vec++;
        if ((a & x.m) !== (x.v & x.m)) begin
            n_miss++;
            $display("FAIL flush_bubble: got %h want %h", a & x.m, x.v & x.m);
        end
        drive(1'b0, '0, '0, 1'b0);
        step();
    endtask

    task automatic test_imm_sext();
        drive(1'b1, mk_i(6'h01, 5'd0, 5'd4, 16'h8000), 32'h400, 1'b0);
        sb.push_back(model(inst, pc4_in));
        step();
        x = sb.pop_front(); a = dut_out(); n_vec++;
        if ((a & x.m) !== (x.v & x.m)
            || ex_imm !== 64'hFFFF_FFFF_FFFF_8000) begin
            n_miss++;
            $display("FAIL imm_neg: got %h want %h", ex_imm,
                     64'hFFFF_FFFF_FFFF_8000);
        end
        drive(1'b1, mk_i(6'h0B, 5'd1, 5'd9, 16'h7FFF), 32'h404, 1'b0);
        sb.push_back(model(inst, pc4_in));
        step();
        x = sb.pop_front(); a = dut_out(); n_vec++;
        if ((a & x.m) !== (x.v & x.m) || ex_imm !== 64'h7FFF) begin
            n_miss++;
            $display("FAIL imm_pos: got %h want %h", ex_imm, 64'h7FFF);
        end
        drive(1'b0, '0, '0, 1'b0);
        step();
    endtask

    task automatic test_opcodes();
        logic [5:0] ops [19];
        for (int i = 0; i < 17; i++) ops[i] = 6'(i);
        ops[17] = 6'h12;
        ops[18] = 6'h3F;
        wb(5'd10, 64'h1111_2222_3333_4444);
        wb(5'd11, 64'h8000_0000_0000_0001);
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, mk_i(ops[i], 5'd10, 5'd11, 16'h9A3C),
                  32'h1000 + 32'(4 * i), 1'b0);
            sb.push_back(model(inst, pc4_in));
            step();
            x = sb.pop_front(); a = dut_out(); n_vec++;
            if ((a & x.m) !== (x.v & x.m)) begin
                n_miss++;
                $display("FAIL op_%02h: got %h want %h", ops[i],
                         a & x.m, x.v & x.m);
            end
            drive(1'b0, '0, '0, 1'b0);
            sb.push_back(bubble());
            step();
            x = sb.pop_front(); a = dut_out(); n_vec++;
            if ((a & x.m) !== (x.v & x.m)) begin
                n_miss++;
                $display("FAIL idle_%02h: got %h want %h", ops[i],
                         a & x.m, x.v & x.m);
            end
        end
    endtask

    task automatic test_halt_reset();
        drive(1'b1, mk_r(6'h11, 5'd0, 5'd0, 5'd0), 32'h500, 1'b0);
        step();
        n_vec++;
        if (halted !== 1'b1 || stall_if !== 1'b1) begin
            n_miss++;
            $display("FAIL halt_set: got h=%b s=%b want 1 1",
                     halted, stall_if);
        end
        drive(1'b1, mk_r(6'h00, 5'd10, 5'd11, 5'd1), 32'h504, 1'b0);
        sb.push_back(bubble());
        step();
        x = sb.pop_front(); a = dut_out(); n_vec++;
        if ((a & x.m) !== (x.v & x.m) || halted !== 1'b1) begin
            n_miss++;
            $display("FAIL halt_bubble: got %h h=%b want %h h=1",
                     a & x.m, halted, x.v & x.m);
        end
        #2;
        reset = 1'b0;
        #1; n_vec++;
        if (dut_out() !== '0 || halted !== 1'b0 || stall_if !== 1'b0) begin
            n_miss++;
            $display("FAIL halt_reset: got %h h=%b s=%b want 0",
                     dut_out(), halted, stall_if);
        end
        for (int i = 0; i < NR; i++) sh[i] = '0;
        @(negedge clk);
        reset = 1'b1;
        step();
        drive(1'b1, mk_r(6'h00, 5'd10, 5'd11, 5'd2), 32'h600, 1'b0);
        sb.push_back(model(inst, pc4_in));
        step();
        x = sb.pop_front(); a = dut_out(); n_vec++;
        if ((a & x.m) !== (x.v & x.m)) begin
            n_miss++;
            $display("FAIL rf_cleared: got %h want %h", a & x.m, x.v & x.m);
        end
        drive(1'b0, '0, '0, 1'b0);
        step();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_no_stall_dest();
        test_flush_hazard();
        test_imm_sext();
        test_opcodes();
        test_halt_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter D_SIZE, default 32, meaning the register and immediate datapath width.
REQ-002 The block SHALL have parameter NREG, default 32, meaning the register count; AW = $clog2(NREG) is the register address width.
REQ-003 The block SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port if_valid, input, 1, meaning inst and pc4_in are valid this cycle.
REQ-006 The block SHALL have port inst, input, 32, instruction word: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
REQ-007 The block SHALL have port pc4_in, input, 32, meaning PC+4 of inst.
REQ-008 The block SHALL have ports wb_we (input, 1), wb_addr (input, AW) and wb_data (input, D_SIZE), forming the register write port from WB.
REQ-009 The block SHALL have port flush, input, 1, meaning a branch was taken in EX, so the instruction in decode is killed.
REQ-010 The block SHALL have port stall_if, output, 1, meaning IF holds PC and inst this cycle.
REQ-011 The block SHALL have port halted, output, 1, meaning HALT was issued; sticky.
REQ-012 The block SHALL have ID/EX outputs ex_valid (1), ex_opcode (6), ex_rs_val and ex_rt_val (D_SIZE), ex_rd (AW), ex_imm (D_SIZE), ex_pc4 (32), ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write (1 each).

Function
REQ-013 Decode SHALL use opcodes 0x00-0x11: add, addi, sub, subi, mul, muli, or, ori, and, andi, xor, xori, ldw, stw, bz, beq, jr, halt.
- Even opcodes 0x00-0x0A: R-type; rs_val=R[rs], rt_val=R[rt], rd=rd, imm=0, mem_to_reg=1.
- Odd opcodes 0x01-0x0B: I-type; rs_val=R[rs], rt_val=0, rd=rt, mem_to_reg=1.
REQ-014 Opcode ldw SHALL decode as I-type with mem_read=1 and mem_to_reg=1.
REQ-015 Opcode stw SHALL decode with rs_val=R[rs], rt_val=R[rt] (the store data), rd=0, mem_write=1 and mem_to_reg=0.
REQ-016 Opcodes bz and jr SHALL decode with branch=1 and rt_val=0; beq SHALL decode with branch=1 and rt_val=R[rt]; rd SHALL be 0 for all three.
REQ-017 halt and undefined opcodes SHALL zero all data and control fields; an undefined opcode SHALL still issue with ex_valid=1.
REQ-018 ex_imm SHALL be imm[15:0] sign-extended to D_SIZE for all I-type and branch opcodes, and 0 otherwise.
REQ-019 The register file SHALL hold NREG x D_SIZE entries; R[0] SHALL read 0 and SHALL ignore writes.
REQ-020 On wb_we=1 the register file SHALL write wb_data to R[wb_addr] at the clock edge.
REQ-021 When wb_we=1 and wb_addr equals a nonzero source index read in the same cycle, the read SHALL return wb_data (write-through bypass).
REQ-022 Load-use hazard SHALL be detected when ex_valid=1, ex_mem_read=1, ex_rd!=0, and ex_rd equals a source actually used by the current opcode (rs; rt for R-type, stw, beq).
REQ-023 On a load-use hazard: stall_if=1, the next ID/EX content SHALL be a bubble (ex_valid=0, all controls 0), and the instruction SHALL re-decode the next cycle; the stall lasts exactly 1 cycle.
REQ-024 On flush=1: the next ID/EX content SHALL be a bubble, stall_if=0, and flush SHALL take priority over the hazard stall.
REQ-025 When if_valid=0, or halted=1, the next ID/EX content SHALL be a bubble.
REQ-026 Issuing halt (valid, not flushed, not stalled) SHALL set halted=1 the next cycle; halted SHALL stay 1 until reset, and stall_if SHALL equal 1 while halted.
REQ-027 Issue latency SHALL be 1 cycle from a valid decode to the ID/EX outputs; ex_pc4 SHALL carry pc4_in.

Reset
REQ-028 On reset=0, all ID/EX outputs, halted and every register-file entry SHALL be 0 immediately, independent of clk.
REQ-029 Reset mid-stall or mid-halt SHALL clear stall_if combinationally to 0 once the pipeline state is cleared.

Structure
REQ-030 The opcode enum, the D_SIZE default, the id_ex_t packed struct and the decode control struct SHALL live in the shared package.
REQ-031 The register file SHALL be sub-module regfile (parameters D_SIZE and NREG, two read ports, one write port, bypass and R[0] rule).

Verification
REQ-032 The bench SHALL cover: wb writes R5=0x1234 while add reads rs=5 in the same cycle -> ex_rs_val=0x1234 the next cycle.
REQ-033 The bench SHALL cover: ldw R3, then add R4=R3+R2 -> stall_if=1 for one cycle, one bubble (ex_valid=0), then add issues.
REQ-034 The bench SHALL cover: ldw R3, then addi R3 with rt=3 used only as the destination -> no stall.
REQ-035 The bench SHALL cover: flush=1 coincident with a load-use hazard -> bubble, stall_if=0.
REQ-036 The bench SHALL cover: addi with imm=0x8000 and D_SIZE=64 -> ex_imm=0xFFFF_FFFF_FFFF_8000.
REQ-037 The bench SHALL cover: halt issued -> halted=1 the next cycle, ex_valid=0 thereafter; reset=0 -> halted=0 and all outputs 0.
